// File: rtl/voice_mixer.sv
// Time-multiplexed voice mixer: one shared multiplier walks the snapshotted voices,
// accumulates gain-scaled terms and presents a saturated mix with a one-cycle strobe.
module voice_mixer #(
  parameter int NUM_VOICES = 4,
  parameter int BITDEPTH   = 14,
  parameter int VOLBITS    = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           sample_clock,
  input  logic [NUM_VOICES*BITDEPTH-1:0] voices_in,
  input  logic [NUM_VOICES*VOLBITS-1:0]  volume,
  output logic signed [BITDEPTH-1:0]     mix_out,
  output logic                           mix_valid,
  output logic                           busy,
  output logic                           overrun
);

  localparam int PW   = BITDEPTH + VOLBITS + 1;
  localparam int CW   = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 0;
  localparam int ACCW = PW + CW;
  localparam int IW   = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

  localparam logic signed [ACCW-1:0] SAT_MAX = {{(ACCW-BITDEPTH+1){1'b0}}, {(BITDEPTH-1){1'b1}}};
  localparam logic signed [ACCW-1:0] SAT_MIN = {{(ACCW-BITDEPTH+1){1'b1}}, {(BITDEPTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, ACCUM, OUTPUT} state_t;

  state_t                     state, next_state;
  logic                       sample_clock_q;
  logic                       start;
  logic [IW-1:0]              index;
  logic signed [BITDEPTH-1:0] samp_q [NUM_VOICES];
  logic [VOLBITS-1:0]         vol_q  [NUM_VOICES];
  logic signed [ACCW-1:0]     acc;
  logic signed [PW-1:0]       product;
  logic signed [PW-1:0]       term;
  logic signed [BITDEPTH-1:0] sat_value;

  assign start = sample_clock & ~sample_clock_q;
  assign busy  = (state == ACCUM);

  // Volume is zero-extended so the product is a true signed x unsigned multiply.
  assign product = PW'(samp_q[index]) * PW'($signed({1'b0, vol_q[index]}));
  assign term    = product >>> 3;

  always_comb begin
    sat_value = acc[BITDEPTH-1:0];
    if (acc > SAT_MAX) begin
      sat_value = SAT_MAX[BITDEPTH-1:0];
    end else if (acc < SAT_MIN) begin
      sat_value = SAT_MIN[BITDEPTH-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = ACCUM;
      ACCUM:   if (index == IW'(NUM_VOICES - 1)) next_state = OUTPUT;
      OUTPUT:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Edge-detect history resets high so a level already high at release is not an edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sample_clock_q <= 1'b1;
      index          <= '0;
      acc            <= '0;
      mix_out        <= '0;
      mix_valid      <= 1'b0;
      overrun        <= 1'b0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        samp_q[i] <= '0;
        vol_q[i]  <= '0;
      end
    end else begin
      sample_clock_q <= sample_clock;
      mix_valid      <= 1'b0;
      if (start && (state != IDLE)) begin
        overrun <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (start) begin
            acc   <= '0;
            index <= '0;
            for (int i = 0; i < NUM_VOICES; i++) begin
              samp_q[i] <= voices_in[i*BITDEPTH +: BITDEPTH];
              vol_q[i]  <= volume[i*VOLBITS +: VOLBITS];
            end
          end
        end
        ACCUM: begin
          acc   <= acc + ACCW'(term);
          index <= index + IW'(1);
        end
        OUTPUT: begin
          mix_out   <= sat_value;
          mix_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_voice_mixer.sv
// Self-checking bench for voice_mixer: directed table, randomized mixes against an
// arithmetic reference model, and hand-written overrun/abort/snapshot sequences.
module tb_voice_mixer;

  localparam int NV = 4;
  localparam int BD = 14;
  localparam int VB = 4;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   sample_clock;
  logic [NV*BD-1:0]       voices_in;
  logic [NV*VB-1:0]       volume;
  logic signed [BD-1:0]   mix_out;
  logic                   mix_valid;
  logic                   busy;
  logic                   overrun;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    string            name;
    logic [NV*BD-1:0] v;
    logic [NV*VB-1:0] vl;
    int               expected;
  } vec_t;

  vec_t vecs [7];

  voice_mixer #(.NUM_VOICES(NV), .BITDEPTH(BD), .VOLBITS(VB)) dut (
    .clk          (clk),
    .rst          (rst),
    .sample_clock (sample_clock),
    .voices_in    (voices_in),
    .volume       (volume),
    .mix_out      (mix_out),
    .mix_valid    (mix_valid),
    .busy         (busy),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [NV*BD-1:0] v, input logic [NV*VB-1:0] vl);
    voices_in = v;
    volume    = vl;
  endtask

  function automatic logic [NV*BD-1:0] packVoices(input int a, input int b, input int c, input int d);
    return {BD'(d), BD'(c), BD'(b), BD'(a)};
  endfunction

  function automatic logic [NV*VB-1:0] packVols(input int a, input int b, input int c, input int d);
    return {VB'(d), VB'(c), VB'(b), VB'(a)};
  endfunction

  // Reference: sum of floor(sample*volume/8), clamped to the output range.
  function automatic int mixModel(input logic [NV*BD-1:0] v, input logic [NV*VB-1:0] vl);
    int sum = 0;
    for (int i = 0; i < NV; i++) begin
      int s = $signed(v[i*BD +: BD]);
      int g = vl[i*VB +: VB];
      int p = s * g;
      sum += (p >= 0) ? (p / 8) : -((-p + 7) / 8);
    end
    if (sum > 8191) sum = 8191;
    if (sum < -8192) sum = -8192;
    return sum;
  endfunction

  // Runs one mix from a fresh rising edge; optionally swaps inputs one cycle after the edge.
  task automatic doMix(input string name, input int expected, input logic change,
                       input logic [NV*BD-1:0] v2, input logic [NV*VB-1:0] vl2);
    int valids  = 0;
    int validAt = -1;
    int busyErr = 0;
    int got     = 0;
    sample_clock = 1'b1;
    if (busy !== 1'b0) busyErr++;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (k == 1) begin
        sample_clock = 1'b0;
        if (change) applyStimulus(v2, vl2);
      end
      if (busy !== ((k <= 4) ? 1'b1 : 1'b0)) busyErr++;
      if (mix_valid === 1'b1) begin
        valids++;
        if (validAt < 0) begin
          validAt = k;
          got     = int'(mix_out);
        end
      end
    end
    checkOutput({name, " value"}, got, expected);
    checkOutput({name, " valid count"}, valids, 1);
    checkOutput({name, " valid cycle"}, validAt, 6);
    checkOutput({name, " busy cycles"}, busyErr, 0);
  endtask

  logic [NV*BD-1:0] va, vb;
  logic [NV*VB-1:0] la, lb;
  int               valids, validAt, got, busyHigh;

  initial begin
    vecs[0] = '{"single voice",  packVoices(1000, 0, 0, 0),                packVols(8, 0, 0, 0),    1000};
    vecs[1] = '{"sat positive",  packVoices(3000, 3000, 3000, 3000),       packVols(8, 8, 8, 8),    8191};
    vecs[2] = '{"sat negative",  packVoices(-3000, -3000, -3000, -3000),   packVols(8, 8, 8, 8),   -8192};
    vecs[3] = '{"min at vol15",  packVoices(-8192, 0, 0, 0),               packVols(15, 0, 0, 0),  -8192};
    vecs[4] = '{"floor rounding",packVoices(-7, 0, 0, 0),                  packVols(3, 0, 0, 0),     -3};
    vecs[5] = '{"two volumes",   packVoices(100, -40, 0, 0),               packVols(12, 4, 0, 0),   130};
    vecs[6] = '{"all muted",     packVoices(8191, -8192, 5000, -5000),     packVols(0, 0, 0, 0),      0};

    rst          = 1'b1;
    sample_clock = 1'b1;
    applyStimulus(packVoices(1000, 1000, 1000, 1000), packVols(8, 8, 8, 8));
    tick(); tick(); tick();
    rst = 1'b0;
    checkOutput("reset mix_out", int'(mix_out), 0);
    checkOutput("reset mix_valid", int'(mix_valid), 0);
    checkOutput("reset busy", int'(busy), 0);
    checkOutput("reset overrun", int'(overrun), 0);
    valids   = 0;
    busyHigh = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (mix_valid === 1'b1) valids++;
      if (busy === 1'b1) busyHigh++;
    end
    checkOutput("no spurious mix after reset", valids, 0);
    checkOutput("no spurious busy after reset", busyHigh, 0);
    sample_clock = 1'b0;
    tick(); tick();

    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i].v, vecs[i].vl);
      doMix(vecs[i].name, vecs[i].expected, 1'b0, '0, '0);
    end

    for (int i = 0; i < 16; i++) begin
      va = packVoices(int'($urandom_range(0, 16383)) - 8192, int'($urandom_range(0, 16383)) - 8192,
                      int'($urandom_range(0, 16383)) - 8192, int'($urandom_range(0, 16383)) - 8192);
      la = packVols(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                    int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
      applyStimulus(va, la);
      doMix($sformatf("random %0d", i), mixModel(va, la), 1'b0, '0, '0);
    end

    va = packVoices(1200, -300, 450, 7);
    la = packVols(8, 5, 11, 15);
    vb = packVoices(-2500, 600, -10, 33);
    lb = packVols(3, 9, 15, 2);
    applyStimulus(va, la);
    doMix("snapshot old", mixModel(va, la), 1'b1, vb, lb);
    doMix("snapshot new", mixModel(vb, lb), 1'b0, '0, '0);

    checkOutput("overrun before", int'(overrun), 0);
    va = packVoices(500, -200, 300, 0);
    la = packVols(8, 8, 8, 8);
    applyStimulus(va, la);
    valids  = 0;
    validAt = -1;
    got     = 0;
    sample_clock = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (k == 1) sample_clock = 1'b0;
      if (k == 2) sample_clock = 1'b1;
      if (k == 3) sample_clock = 1'b0;
      if (mix_valid === 1'b1) begin
        valids++;
        if (validAt < 0) begin
          validAt = k;
          got     = int'(mix_out);
        end
      end
    end
    checkOutput("overrun valid count", valids, 1);
    checkOutput("overrun valid cycle", validAt, 6);
    checkOutput("overrun value", got, mixModel(va, la));
    checkOutput("overrun set", int'(overrun), 1);
    doMix("after overrun", mixModel(va, la), 1'b0, '0, '0);
    checkOutput("overrun sticky", int'(overrun), 1);

    applyStimulus(packVoices(2000, 0, 0, 0), packVols(8, 0, 0, 0));
    sample_clock = 1'b1;
    tick();
    sample_clock = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    checkOutput("abort mix_out", int'(mix_out), 0);
    checkOutput("abort busy", int'(busy), 0);
    checkOutput("abort mix_valid", int'(mix_valid), 0);
    checkOutput("abort overrun", int'(overrun), 0);
    tick(); tick();
    rst = 1'b0;
    valids = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (mix_valid === 1'b1) valids++;
    end
    checkOutput("abort no valid", valids, 0);
    checkOutput("abort mix_out held", int'(mix_out), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
